// File: rtl/grid_memory_ctrl_if.sv
// grid_memory_ctrl_if: request/response bus between game logic and the grid store.
//   master : drives req_valid/req_write/req_x/req_y/req_data, receives req_ready and rd_*
//   slave  : the grid store side of the same signals
interface grid_memory_ctrl_if #(
  parameter int unsigned COORD_W = 5,
  parameter int unsigned CELL_W  = 2
) ();
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [COORD_W-1:0] req_x;
  logic [COORD_W-1:0] req_y;
  logic [CELL_W-1:0]  req_data;
  logic               rd_valid;
  logic [CELL_W-1:0]  rd_data;
  logic               rd_err;

  modport master (
    output req_valid, req_write, req_x, req_y, req_data,
    input  req_ready, rd_valid, rd_data, rd_err
  );

  modport slave (
    input  req_valid, req_write, req_x, req_y, req_data,
    output req_ready, rd_valid, rd_data, rd_err
  );
endinterface

// File: rtl/grid_memory_ctrl.sv
// grid_memory_ctrl: GRID_W x GRID_H cell store for the snake game, 1-based (x,y) addressing.
// Clears itself after reset, seeds the initial snake and food, then serves a handshaked
// read/write port and an always-on registered scan port for the display.
// Ports:
//   clk_i        clock, all state on posedge
//   rst_ni       asynchronous active-low reset
//   bus          grid_memory_ctrl_if.slave request/response bus
//   scan_x_i/y_i display scan coordinate
//   scan_data_o  cell at the scan coordinate, one cycle later (0 if out of range or not ready)
//   occ_count_o  number of nonzero cells
//   init_done_o  high once clear and seed have completed
//
// state   | meaning
// --------+--------------------------------------------------
// S_CLEAR | writing 0 to every cell, ptr 0..N-1
// S_INIT  | seeding snake cells (ptr 0..SNAKE_LEN-1), then food
// S_IDLE  | accepting requests (req_ready=1)
// S_WR2   | committing a latched write, returning the old value
module grid_memory_ctrl #(
  parameter int unsigned GRID_W    = 15,
  parameter int unsigned GRID_H    = 15,
  parameter int unsigned CELL_W    = 2,
  parameter int unsigned COORD_W   = 5,
  parameter int unsigned SNAKE_LEN = 3,
  parameter int unsigned FOOD_X    = 11,
  parameter int unsigned FOOD_Y    = 4,
  localparam int unsigned N        = GRID_W * GRID_H,
  localparam int unsigned CNT_W    = $clog2(N + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  grid_memory_ctrl_if.slave   bus,
  input  logic [COORD_W-1:0]  scan_x_i,
  input  logic [COORD_W-1:0]  scan_y_i,
  output logic [CELL_W-1:0]   scan_data_o,
  output logic [CNT_W-1:0]    occ_count_o,
  output logic                init_done_o
);

  localparam int unsigned ADDR_W = $clog2(N);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] SEED_LAST = ADDR_W'(SNAKE_LEN);
  localparam logic [ADDR_W-1:0] FOOD_ADDR = ADDR_W'(GRID_W * (FOOD_Y - 1) + FOOD_X - 1);
  localparam logic [CNT_W-1:0]  N_CNT     = CNT_W'(N);

  typedef enum logic [1:0] {S_CLEAR, S_INIT, S_IDLE, S_WR2} state_e;

  function automatic logic in_range(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return (x != '0) && (32'(x) <= GRID_W) && (y != '0) && (32'(y) <= GRID_H);
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
    int unsigned a;
    a = GRID_W * (32'(y) - 32'd1) + 32'(x) - 32'd1;
    return a[ADDR_W-1:0];
  endfunction

  logic [CELL_W-1:0] mem_q [N];

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CELL_W-1:0] wdata_q;
  logic [CELL_W-1:0] old_q;
  logic              wr_ok_q;
  logic              ready_q;
  logic              rd_valid_q;
  logic [CELL_W-1:0] rd_data_q;
  logic              rd_err_q;
  logic [CELL_W-1:0] scan_data_q;
  logic [CNT_W-1:0]  occ_q;
  logic              init_done_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [CELL_W-1:0] mem_wdata;

  logic              req_in;
  logic [ADDR_W-1:0] req_addr;
  logic [CELL_W-1:0] req_cell;
  logic              scan_in;
  logic [CELL_W-1:0] scan_cell;
  logic              accept;

  // Out-of-range coordinates never index the array; they read as 0.
  assign req_in    = in_range(bus.req_x, bus.req_y);
  assign req_addr  = cell_addr(bus.req_x, bus.req_y);
  assign req_cell  = req_in ? mem_q[req_addr] : '0;
  assign scan_in   = in_range(scan_x_i, scan_y_i);
  assign scan_cell = scan_in ? mem_q[cell_addr(scan_x_i, scan_y_i)] : '0;
  assign accept    = bus.req_valid && ready_q;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = '0;
    unique case (state_q)
      S_CLEAR: mem_we = 1'b1;
      S_INIT: begin
        mem_we = 1'b1;
        // Snake occupies row 1, so its address is simply x-1 = ptr.
        if (ptr_q == SEED_LAST) begin
          mem_waddr = FOOD_ADDR;
          mem_wdata = CELL_W'(1);
        end else begin
          mem_wdata = CELL_W'(2);
        end
      end
      S_WR2: begin
        mem_we    = wr_ok_q;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  // Storage is deliberately not reset; CLEAR overwrites every cell instead.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_CLEAR;
      ptr_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      old_q       <= '0;
      wr_ok_q     <= 1'b0;
      ready_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_err_q    <= 1'b0;
      scan_data_q <= '0;
      occ_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_data_q   <= '0;
      // Reads the array before this edge's commit, so a same-cycle write shows the old value.
      scan_data_q <= (init_done_q && scan_in) ? scan_cell : '0;
      unique case (state_q)
        S_CLEAR: begin
          if (ptr_q == LAST_ADDR) begin
            ptr_q   <= '0;
            state_q <= S_INIT;
          end else begin
            ptr_q <= ptr_q + ADDR_W'(1);
          end
        end
        S_INIT: begin
          // Every seed write lands on a freshly cleared cell.
          if (occ_q != N_CNT) occ_q <= occ_q + CNT_W'(1);
          if (ptr_q == SEED_LAST) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            init_done_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + ADDR_W'(1);
          end
        end
        S_IDLE: begin
          if (accept) begin
            if (bus.req_write) begin
              state_q <= S_WR2;
              ready_q <= 1'b0;
              addr_q  <= req_addr;
              wdata_q <= bus.req_data;
              old_q   <= req_cell;
              wr_ok_q <= req_in;
            end else begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= req_cell;
              rd_err_q   <= !req_in;
            end
          end
        end
        S_WR2: begin
          state_q    <= S_IDLE;
          ready_q    <= 1'b1;
          rd_valid_q <= 1'b1;
          rd_err_q   <= !wr_ok_q;
          rd_data_q  <= old_q;
          if (wr_ok_q) begin
            if (old_q == '0 && wdata_q != '0 && occ_q != N_CNT) begin
              occ_q <= occ_q + CNT_W'(1);
            end else if (old_q != '0 && wdata_q == '0 && occ_q != '0) begin
              occ_q <= occ_q - CNT_W'(1);
            end
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_err    = rd_err_q;
  assign scan_data_o   = scan_data_q;
  assign occ_count_o   = occ_q;
  assign init_done_o   = init_done_q;

endmodule

// File: tb/tb_grid_memory_ctrl.sv
// tb_grid_memory_ctrl: randomized and directed checks of grid_memory_ctrl against a
// cell-array reference model of the game grid.
module tb_grid_memory_ctrl;
  localparam int GW = 15;
  localparam int GH = 15;
  localparam int NC = GW * GH;
  localparam int INIT_CYC = NC + 3 + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] scan_x = '0;
  logic [4:0] scan_y = '0;
  logic [1:0] scan_data;
  logic [7:0] occ;
  logic       init_done;

  int grid [17][17];
  int vectors = 0;
  int miscompares = 0;

  grid_memory_ctrl_if #(.COORD_W(5), .CELL_W(2)) bus ();

  grid_memory_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .scan_x_i    (scan_x),
    .scan_y_i    (scan_y),
    .scan_data_o (scan_data),
    .occ_count_o (occ),
    .init_done_o (init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_in(input int x, input int y);
    return x >= 1 && x <= GW && y >= 1 && y <= GH;
  endfunction

  function automatic int m_cell(input int x, input int y);
    if (!m_in(x, y)) return 0;
    return grid[x][y];
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int x = 1; x <= GW; x++)
      for (int y = 1; y <= GH; y++)
        if (grid[x][y] != 0) c++;
    return c;
  endfunction

  task automatic m_seed();
    for (int x = 0; x < 17; x++)
      for (int y = 0; y < 17; y++) grid[x][y] = 0;
    for (int x = 1; x <= 3; x++) grid[x][1] = 2;
    grid[11][4] = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 500) begin
      tick();
      n++;
    end
    if (n == 500) chk("ready_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_rd_err", bus.rd_err, 0);
    chk("rst_scan", scan_data, 0);
    chk("rst_occ", occ, 0);
    chk("rst_init_done", init_done, 0);
  endtask

  // Release reset and count edges until init_done; nothing may respond before then.
  task automatic release_and_init();
    int cyc = 0;
    bit bad = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    while (!init_done && cyc < 1000) begin
      tick();
      cyc++;
      if (!init_done && (bus.req_ready || bus.rd_valid || scan_data != 0)) bad = 1;
    end
    chk("init_cycles", cyc, INIT_CYC);
    chk("init_quiet", bad, 0);
    chk("init_occ", occ, 4);
    chk("init_ready", bus.req_ready, 1);
  endtask

  task automatic do_read(input int x, input int y);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_x     = 5'(x);
    bus.req_y     = 5'(y);
    bus.req_data  = 2'($urandom_range(0, 3));
    wait_ready();
    tick();
    chk("rd_valid", bus.rd_valid, 1);
    chk("rd_err", bus.rd_err, m_in(x, y) ? 0 : 1);
    chk("rd_data", bus.rd_data, m_cell(x, y));
    chk("rd_scan", scan_data, m_cell(int'(scan_x), int'(scan_y)));
    chk("rd_occ", occ, m_count());
  endtask

  task automatic do_write(input int x, input int y, input int d);
    int old_v;
    int scan_v;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_x     = 5'(x);
    bus.req_y     = 5'(y);
    bus.req_data  = 2'(d);
    wait_ready();
    tick();
    bus.req_valid = 1'b0;
    chk("wr_busy", bus.req_ready, 0);
    chk("wr_novalid", bus.rd_valid, 0);
    old_v  = m_cell(x, y);
    scan_v = m_cell(int'(scan_x), int'(scan_y));
    tick();
    chk("wr_valid", bus.rd_valid, 1);
    chk("wr_err", bus.rd_err, m_in(x, y) ? 0 : 1);
    chk("wr_old", bus.rd_data, old_v);
    chk("wr_scan", scan_data, scan_v);
    if (m_in(x, y)) grid[x][y] = d;
    chk("wr_occ", occ, m_count());
    chk("wr_ready", bus.req_ready, 1);
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    tick();
    chk("idle_valid", bus.rd_valid, 0);
    chk("idle_err", bus.rd_err, 0);
    chk("idle_scan", scan_data, m_cell(int'(scan_x), int'(scan_y)));
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_data  = '0;
    #1 rst_n = 1'b0;
    #20;
    check_reset_outputs();

    // A read held during initialisation must wait, not be dropped.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_x     = 5'd11;
    bus.req_y     = 5'd4;
    release_and_init();
    m_seed();

    do_read(11, 4);
    chk("food", bus.rd_data, 1);
    do_read(2, 1);
    chk("snake", bus.rd_data, 2);
    do_read(7, 7);
    idle();

    do_write(5, 5, 2);
    chk("occ5", occ, 5);
    do_read(5, 5);
    do_write(5, 5, 1);
    chk("occ5b", occ, 5);
    do_write(1, 1, 0);
    chk("occ4", occ, 4);
    do_read(0, 3);
    do_read(16, 1);
    do_write(0, 5, 3);
    do_write(4, 16, 2);
    idle();

    scan_x = 5'd3;
    scan_y = 5'd3;
    idle();
    do_write(3, 3, 2);
    idle();
    chk("scan_new", scan_data, 2);

    for (int i = 0; i < 300; i++) begin
      int op;
      int x;
      int y;
      op     = int'($urandom_range(0, 9));
      x      = int'($urandom_range(0, 16));
      y      = int'($urandom_range(0, 16));
      scan_x = 5'($urandom_range(0, 16));
      scan_y = 5'($urandom_range(0, 16));
      if (op < 5)      do_read(x, y);
      else if (op < 9) do_write(x, y, int'($urandom_range(0, 3)));
      else             idle();
      chk("occ_bound", (occ <= 8'(NC)) ? 1 : 0, 1);
    end
    idle();

    // Reset while a write sits in WR2: the write must vanish.
    scan_x = 5'd6;
    scan_y = 5'd6;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_x     = 5'd6;
    bus.req_y     = 5'd6;
    bus.req_data  = 2'd2;
    wait_ready();
    tick();
    bus.req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    m_seed();
    release_and_init();
    do_read(6, 6);
    do_read(5, 5);
    do_read(3, 3);
    do_read(1, 1);
    do_read(11, 4);
    for (int i = 0; i < 20; i++) begin
      scan_x = 5'($urandom_range(0, 16));
      scan_y = 5'($urandom_range(0, 16));
      do_read(int'($urandom_range(1, 15)), int'($urandom_range(1, 15)));
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
